cache_fill_fsm: RTL and testbench

- Read-side initiator for the 16-bit byte-addressable data memory; it is the requester that talks to the memory's enable/wr/addr interface.
- On a cache miss it fetches the whole 16-byte block as 8 sequential word reads, streams each returned word into the cache data array, and pulses a tag-array write on completion.
- Sits between the cache miss-detect logic and the pipelined multicycle memory.

---
 rtl/cache_fill_fsm.sv | 77 +++++++
 tb/tb_cache_fill_fsm.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_fsm.sv
// rtl/cache_fill_fsm.sv - cache miss block fill: issues WORDS sequential reads and streams responses into the data array
module cache_fill_fsm #(
    parameter int ADDR_WIDTH  = 16,
    parameter int WORDS       = 8,
    parameter int OFFSET_BITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  miss_detected,
    input  logic [ADDR_WIDTH-1:0] miss_address,
    output logic                  fsm_busy,
    output logic                  mem_enable,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_data_valid,
    input  logic [15:0]           mem_data,
    output logic                  write_data_array,
    output logic [ADDR_WIDTH-1:0] cache_wr_addr,
    output logic [15:0]           cache_wr_data,
    output logic                  write_tag_array
);

    localparam int CNT_W = $clog2(WORDS) + 1;
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((1 << OFFSET_BITS) - 1);

    typedef enum logic {IDLE, FILL} state_t;

    state_t                state;
    logic [CNT_W-1:0]      issue_cnt;
    logic [CNT_W-1:0]      recv_cnt;
    logic [ADDR_WIDTH-1:0] base;
    logic                  issue_ok;

    assign issue_ok = (state == FILL) && (issue_cnt < CNT_W'(WORDS));

    // Requests and responses run independently; both offsets stay inside the aligned block.
    assign mem_enable       = issue_ok;
    assign mem_wr           = 1'b0;
    assign mem_addr         = issue_ok ? (base | (ADDR_WIDTH'(issue_cnt) << 1)) : '0;
    assign write_data_array = (state == FILL) && mem_data_valid && (recv_cnt < CNT_W'(WORDS));
    assign cache_wr_addr    = write_data_array ? (base | (ADDR_WIDTH'(recv_cnt) << 1)) : '0;
    assign cache_wr_data    = mem_data;
    assign write_tag_array  = write_data_array && (recv_cnt == CNT_W'(WORDS - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            base      <= '0;
            fsm_busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss_detected) begin
                        base      <= miss_address & ~OFF_MASK;
                        issue_cnt <= '0;
                        recv_cnt  <= '0;
                        state     <= FILL;
                        fsm_busy  <= 1'b1;
                    end
                end
                FILL: begin
                    if (issue_ok)
                        issue_cnt <= issue_cnt + 1'b1;
                    if (write_data_array)
                        recv_cnt <= recv_cnt + 1'b1;
                    if (write_tag_array) begin
                        state    <= IDLE;
                        fsm_busy <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb/tb_cache_fill_fsm.sv - self-checking bench for cache_fill_fsm with a queue-based reference model and memory model
module tb_cache_fill_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        miss_detected = 1'b0;
    logic [15:0] miss_address = 16'h0;
    logic        fsm_busy;
    logic        mem_enable;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic        mem_data_valid = 1'b0;
    logic [15:0] mem_data = 16'h0;
    logic        write_data_array;
    logic [15:0] cache_wr_addr;
    logic [15:0] cache_wr_data;
    logic        write_tag_array;

    cache_fill_fsm #(.ADDR_WIDTH(16), .WORDS(8), .OFFSET_BITS(4)) dut (
        .clk(clk), .rst(rst),
        .miss_detected(miss_detected), .miss_address(miss_address),
        .fsm_busy(fsm_busy), .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_data_valid(mem_data_valid), .mem_data(mem_data),
        .write_data_array(write_data_array), .cache_wr_addr(cache_wr_addr),
        .cache_wr_data(cache_wr_data), .write_tag_array(write_tag_array)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        int          lat;
        int          bub_after;
        int          bub_len;
        logic [15:0] exp_base;
        int          exp_busy;
    } vec_t;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    // Memory model: in-order responses after lat cycles, optional bubble after bub_after deliveries.
    logic [15:0] mem_q[$];
    int          mem_rdy[$];
    int          lat = 4;
    int          bub_after = 0;
    int          bub_rem = 0;
    int          delivered = 0;
    bit          spur_en = 1'b0;
    bit          checking = 1'b0;

    // Reference model: the outstanding request and write addresses of the current fill.
    bit          m_busy = 1'b0;
    logic [15:0] req_q[$];
    logic [15:0] wr_q[$];

    function automatic logic [15:0] mem_f(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic m, input logic [15:0] a);
        logic        e_busy, e_en, e_wr, e_tag;
        logic [15:0] e_addr, e_waddr, blk;
        @(negedge clk);
        rst = r;
        miss_detected = m;
        miss_address = a;
        mem_data_valid = 1'b0;
        mem_data = 16'($urandom);
        if (mem_q.size() > 0 && mem_rdy[0] <= cyc) begin
            if (delivered == bub_after && bub_rem > 0) begin
                bub_rem--;
            end else begin
                mem_data_valid = 1'b1;
                mem_data = mem_f(mem_q[0]);
                void'(mem_q.pop_front());
                void'(mem_rdy.pop_front());
                delivered++;
            end
        end else if (spur_en && !m_busy && mem_q.size() == 0 && $urandom_range(0, 1) == 1) begin
            mem_data_valid = 1'b1;
        end
        #1;
        e_busy  = m_busy;
        e_en    = m_busy && req_q.size() > 0;
        e_addr  = e_en ? req_q[0] : 16'h0;
        e_wr    = m_busy && mem_data_valid && wr_q.size() > 0;
        e_waddr = e_wr ? wr_q[0] : 16'h0;
        e_tag   = e_wr && wr_q.size() == 1;
        if (checking) begin
            chk("fsm_busy", fsm_busy, e_busy);
            chk("mem_enable", mem_enable, e_en);
            chk("mem_wr", mem_wr, 0);
            if (e_en) chk("mem_addr", mem_addr, e_addr);
            chk("write_data_array", write_data_array, e_wr);
            chk("write_tag_array", write_tag_array, e_tag);
            if (e_wr) begin
                chk("cache_wr_addr", cache_wr_addr, e_waddr);
                chk("cache_wr_data", cache_wr_data, mem_f(e_waddr));
            end
            if (mem_enable) begin
                mem_q.push_back(mem_addr);
                mem_rdy.push_back(cyc + lat);
            end
        end
        if (!r) begin
            m_busy = 1'b0;
            req_q.delete();
            wr_q.delete();
        end else if (!m_busy) begin
            if (m) begin
                blk = a & 16'hFFF0;
                for (int i = 0; i < 8; i++) begin
                    req_q.push_back(16'(blk + 2 * i));
                    wr_q.push_back(16'(blk + 2 * i));
                end
                m_busy = 1'b1;
            end
        end else begin
            if (e_en) void'(req_q.pop_front());
            if (e_wr) void'(wr_q.pop_front());
            if (e_tag) m_busy = 1'b0;
        end
        cyc++;
    endtask

    vec_t tbl[6];

    initial begin
        int          busy_cnt, n, wr_cnt;
        logic [15:0] first_addr, last_addr;
        bit          got_first;

        tbl[0] = '{16'h1236, 4, 0, 0, 16'h1230, 12};
        tbl[1] = '{16'h1236, 4, 4, 3, 16'h1230, 15};
        tbl[2] = '{16'hFFFE, 1, 0, 0, 16'hFFF0, 9};
        tbl[3] = '{16'h0004, 7, 0, 0, 16'h0000, 15};
        tbl[4] = '{16'hABCD, 2, 7, 5, 16'hABC0, 15};
        tbl[5] = '{16'h8001, 3, 2, 1, 16'h8000, 12};

        // Reset held two cycles with a pending miss.
        step(1'b0, 1'b1, 16'h1236);
        checking = 1'b1;
        step(1'b0, 1'b1, 16'h1236);
        chk("reset_mem_addr", mem_addr, 0);
        chk("reset_cache_wr_addr", cache_wr_addr, 0);
        spur_en = 1'b1;
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 16'h0);

        for (int t = 0; t < 6; t++) begin
            lat = tbl[t].lat; bub_after = tbl[t].bub_after; bub_rem = tbl[t].bub_len; delivered = 0;
            step(1'b1, 1'b1, tbl[t].addr);
            busy_cnt = 0; n = 0; got_first = 1'b0; first_addr = 16'h0;
            do begin
                step(1'b1, 1'b0, 16'($urandom));
                if (fsm_busy) busy_cnt++;
                if (mem_enable && !got_first) begin first_addr = mem_addr; got_first = 1'b1; end
                n++;
            end while (m_busy && n < 100);
            chk("vec_timeout", m_busy, 0);
            chk("vec_busy_cycles", busy_cnt, tbl[t].exp_busy);
            chk("vec_first_addr", first_addr, tbl[t].exp_base);
            step(1'b1, 1'b0, 16'h0);
            chk("vec_busy_cleared", fsm_busy, 0);
        end

        // Back-to-back misses with miss_detected held across the first fill.
        lat = 2; bub_rem = 0; delivered = 0;
        step(1'b1, 1'b1, 16'hFFF2);
        n = 0; last_addr = 16'h0;
        do begin
            step(1'b1, 1'b1, 16'h0004);
            if (mem_enable) last_addr = mem_addr;
            n++;
        end while (m_busy && n < 100);
        chk("b2b_last_addr", last_addr, 16'hFFFE);
        step(1'b1, 1'b1, 16'h0004);
        chk("b2b_idle_gap", fsm_busy, 0);
        step(1'b1, 1'b0, 16'h0);
        chk("b2b_second_busy", fsm_busy, 1);
        chk("b2b_second_addr", mem_addr, 16'h0000);
        n = 0;
        while (m_busy && n < 100) begin step(1'b1, 1'b0, 16'h0); n++; end
        chk("b2b_timeout", m_busy, 0);

        // Reset after the 5th response; the remaining three must be ignored.
        lat = 3; bub_after = 5; bub_rem = 3; delivered = 0;
        step(1'b1, 1'b1, 16'h4442);
        n = 0;
        while (delivered < 5 && n < 50) begin step(1'b1, 1'b0, 16'h0); n++; end
        chk("rst_mid_reached", delivered, 5);
        step(1'b0, 1'b0, 16'h0);
        step(1'b1, 1'b0, 16'h0);
        chk("rst_mid_busy", fsm_busy, 0);
        chk("rst_mid_enable", mem_enable, 0);
        chk("rst_mid_addr", mem_addr, 0);
        chk("rst_mid_wda", write_data_array, 0);
        chk("rst_mid_tag", write_tag_array, 0);
        chk("rst_mid_wr_addr", cache_wr_addr, 0);
        wr_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 16'h0);
            if (write_data_array || write_tag_array) wr_cnt++;
        end
        chk("rst_mid_drained", delivered, 8);
        chk("rst_mid_stale_writes", wr_cnt, 0);

        // Randomized fills with bubbles, spurious misses during FILL and spurious valids in IDLE.
        for (int k = 0; k < 25; k++) begin
            lat = $urandom_range(1, 6);
            bub_after = $urandom_range(0, 7);
            bub_rem = $urandom_range(0, 3);
            delivered = 0;
            step(1'b1, 1'b1, 16'($urandom));
            n = 0;
            while (m_busy && n < 200) begin
                step(1'b1, 1'($urandom_range(0, 1)), 16'($urandom));
                n++;
            end
            chk("rand_timeout", m_busy, 0);
            for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
